lx32_muldiv: RTL
================

LX32_MULDIV -- requirements
Module: lx32_muldiv

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning operand/result width in bits (even, >= 8).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port flush  input  1  synchronous abort of any in-flight operation.
REQ-005 SHALL have port in_valid  input  1  request valid.
REQ-006 SHALL have port in_ready  output  1  unit can accept a request.
REQ-007 SHALL have port op  input  muldiv_op_e (3)  MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-008 SHALL have ports src_a, src_b  input  WIDTH  operands (rs1, rs2 semantics).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port result  output  WIDTH  selected product half, quotient or remainder.
REQ-012 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 SHALL implement FSM IDLE -> CALC -> DONE -> IDLE; in_ready = (state==IDLE).
REQ-014 SHALL accept a request on an edge where in_valid && in_ready, latching op and operands.
REQ-015 SHALL, in CALC, run an iterative radix-2 algorithm (shift-add multiply, restoring divide on magnitudes) for exactly WIDTH cycles, then enter DONE.
REQ-016 SHALL give normal latency: accept at edge N, out_valid high from edge N+WIDTH+1.
REQ-017 SHALL hold out_valid and result stable in DONE until out_valid && out_ready, then return to IDLE on that edge; no new request is accepted on that edge.
REQ-018 SHALL return the low WIDTH bits for MUL and the high WIDTH bits of the 2*WIDTH product for MULH (s*s), MULHSU (s*u) and MULHU (u*u).
REQ-019 SHALL truncate DIV quotients toward zero; the REM sign SHALL follow the dividend.
REQ-020 SHALL, on divide by zero, bypass CALC (DONE at N+1) with quotient all-ones and remainder src_a.
REQ-021 SHALL, on signed overflow (DIV/REM with src_a = most negative, src_b = all-ones), bypass CALC (DONE at N+1) with quotient src_a and remainder 0.
REQ-022 SHALL, when flush is high, go to IDLE on that edge with out_valid low next cycle, overriding accept and handshake; a request presented with flush is dropped.

Reset
REQ-023 SHALL, while rst is high at an edge, force state IDLE, out_valid 0, busy 0, result 0 and iteration counter 0, regardless of flush or in_valid.
REQ-024 SHALL give in_ready 1 on the first cycle after reset deassertion; rst mid-operation discards the operation with no out_valid.

Configuration
REQ-025 SHALL, with macro LX32_MULDIV_FAST_MUL_EN defined, compute all four multiply ops with a single registered full-width multiplier, skipping CALC (DONE at N+1); divides are unchanged.
REQ-026 SHALL, without LX32_MULDIV_FAST_MUL_EN, use the iterative path of REQ-015 for multiplies with no hardware multiplier inferred.

Structure
REQ-027 SHALL place muldiv_op_e in lx32_pkg beside alu_op_e, plus a constant MULDIV_OP_W = 3.
REQ-028 SHALL contain the divider datapath (magnitude conversion, restoring step, sign fix-up) in sub-module lx32_div_iter; the FSM, handshake and multiply path remain in lx32_muldiv.

Verification (WIDTH=32, both macro settings)
REQ-029 SHALL check MUL 7 * 0xFFFFFFFD -> 0xFFFFFFEB; MULH 0x80000000 * 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF * 0xFFFFFFFF -> 0xFFFFFFFE; out_valid at N+33 (N+1 with the macro).
REQ-030 SHALL check DIV 0xFFFFFFEC / 3 -> 0xFFFFFFFA and REM -> 0xFFFFFFFE, out_valid at N+33.
REQ-031 SHALL check DIVU 0x1234 / 0 -> 0xFFFFFFFF and REMU -> 0x1234, out_valid at N+1.
REQ-032 SHALL check DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 and REM -> 0, out_valid at N+1.
REQ-033 SHALL check out_ready held low 5 cycles in DONE: result stable, in_ready 0; a back-to-back request is accepted the edge after the handshake.
REQ-034 SHALL check flush asserted 10 cycles into CALC: IDLE next edge, out_valid never asserts, and the next request yields a correct result.

Source files
------------

// File: rtl/lx32_pkg.sv
`default_nettype none
// ============================================================================
// Module : lx32_pkg
// Purpose: Shared types for the lx32 execute units: ALU and mul/div op codes,
//          mul/div operation width and the mul/div controller states.
// Ports  : none (package)
// Rev    : 1.0  initial release
// ============================================================================
package lx32_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  localparam int MULDIV_OP_W = 3;

  // Encoding follows the RV32M funct3 field.
  typedef enum logic [MULDIV_OP_W-1:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/lx32_div_iter.sv
`default_nettype none
// ============================================================================
// Module : lx32_div_iter
// Purpose: Radix-2 restoring divider datapath working on operand magnitudes.
//          'load' captures the operands (converted to magnitudes), each
//          'step' retires one quotient bit; quotient/remainder outputs carry
//          the sign fix-up (quotient truncated toward zero, remainder takes
//          the dividend's sign).
// Ports  : clk, rst          clock, synchronous active-high reset
//          load, step        capture operands / perform one iteration
//          is_signed         treat operands as two's complement
//          dividend, divisor WIDTH-bit operands
//          quotient, remainder signed-corrected results
// Rev    : 1.0  initial release
// ============================================================================
module lx32_div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             step,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs;
  logic             neg_q;
  logic             neg_r;

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   shifted;
  logic             fits;
  logic [WIDTH-1:0] diff;

  assign a_neg = is_signed & dividend[WIDTH-1];
  assign b_neg = is_signed & divisor[WIDTH-1];
  assign a_mag = a_neg ? -dividend : dividend;
  assign b_mag = b_neg ? -divisor : divisor;

  // Quotient register doubles as the dividend shift register.
  assign shifted = {rem, quo[WIDTH-1]};
  assign fits    = shifted >= {1'b0, dvs};
  // When the divisor fits, the true difference is below 2^WIDTH, so the
  // low WIDTH bits of the subtraction are exact.
  assign diff    = shifted[WIDTH-1:0] - dvs;

  always_ff @(posedge clk) begin
    if (rst) begin
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (load) begin
      quo   <= a_mag;
      rem   <= '0;
      dvs   <= b_mag;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
    end else if (step) begin
      if (fits) begin
        rem <= diff;
        quo <= {quo[WIDTH-2:0], 1'b1};
      end else begin
        rem <= shifted[WIDTH-1:0];
        quo <= {quo[WIDTH-2:0], 1'b0};
      end
    end
  end

  assign quotient  = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;

endmodule
`default_nettype wire

// File: rtl/lx32_muldiv.sv
`default_nettype none
// ============================================================================
// Module : lx32_muldiv
// Purpose: RV32M-style multiply/divide unit with valid/ready handshakes.
//          FSM IDLE -> CALC -> DONE -> IDLE. Iterative radix-2 multiply and
//          divide take WIDTH iterations plus one finishing cycle; divide by
//          zero and signed overflow skip straight to DONE.
//          Macro LX32_MULDIV_FAST_MUL_EN: when defined, multiplies use one
//          registered full-width multiplier and finish one cycle after accept.
// Ports  : clk, rst            clock, synchronous active-high reset
//          flush               abort any in-flight operation
//          in_valid, in_ready  request handshake (op, src_a, src_b)
//          out_valid, out_ready result handshake (result)
//          busy                high whenever the unit is not idle
// Rev    : 1.0  initial release
// ============================================================================
module lx32_muldiv
  import lx32_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  muldiv_op_e       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             busy
);

  localparam int               CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH);
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  md_state_e        state;
  muldiv_op_e       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             is_div;
  logic             is_rem;
  logic             div_signed_q;
  logic             div_signed_in;
  logic             div_zero;
  logic             div_ovf;
  logic             div_step;
  logic [WIDTH-1:0] div_quo;
  logic [WIDTH-1:0] div_rem;
  logic             mul_fin;
  logic [WIDTH-1:0] mul_res;

  assign in_ready      = (state == ST_IDLE);
  assign busy          = (state != ST_IDLE);
  assign accept        = (state == ST_IDLE) && in_valid && !flush;

  assign is_div        = (op_q == MD_DIV) || (op_q == MD_DIVU) ||
                         (op_q == MD_REM) || (op_q == MD_REMU);
  assign is_rem        = (op_q == MD_REM) || (op_q == MD_REMU);
  assign div_signed_q  = (op_q == MD_DIV) || (op_q == MD_REM);
  assign div_signed_in = (op == MD_DIV) || (op == MD_REM);
  assign div_zero      = (b_q == '0);
  assign div_ovf       = div_signed_q && (a_q == MOST_NEG) && (b_q == '1);
  assign div_step      = (state == ST_CALC) && is_div && (cnt != CNT_LAST);

  lx32_div_iter #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk       (clk),
    .rst       (rst),
    .load      (accept),
    .step      (div_step),
    .is_signed (div_signed_in),
    .dividend  (src_a),
    .divisor   (src_b),
    .quotient  (div_quo),
    .remainder (div_rem)
  );

`ifdef LX32_MULDIV_FAST_MUL_EN
  logic             fa_sx;
  logic             fb_sx;
  logic [2*WIDTH-1:0] fa;
  logic [2*WIDTH-1:0] fb;
  logic [2*WIDTH-1:0] fprod;

  // Low 2*WIDTH bits of the product of sign-extended operands give the
  // exact signed/unsigned product for every multiply flavour.
  assign fa_sx   = ((op_q == MD_MULH) || (op_q == MD_MULHSU)) & a_q[WIDTH-1];
  assign fb_sx   = (op_q == MD_MULH) & b_q[WIDTH-1];
  assign fa      = {{WIDTH{fa_sx}}, a_q};
  assign fb      = {{WIDTH{fb_sx}}, b_q};
  assign fprod   = fa * fb;
  assign mul_fin = 1'b1;
  assign mul_res = (op_q == MD_MUL) ? fprod[WIDTH-1:0] : fprod[2*WIDTH-1:WIDTH];
`else
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic               mneg;
  logic               ma_neg;
  logic               mb_neg;
  logic [2*WIDTH-1:0] prod;

  // Shift-add on magnitudes; the sign is applied once at the end.
  assign ma_neg  = ((op == MD_MULH) || (op == MD_MULHSU)) & src_a[WIDTH-1];
  assign mb_neg  = (op == MD_MULH) & src_b[WIDTH-1];
  assign prod    = mneg ? -acc : acc;
  assign mul_fin = (cnt == CNT_LAST);
  assign mul_res = (op_q == MD_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      mneg   <= 1'b0;
    end else if (accept) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, (ma_neg ? -src_a : src_a)};
      mplier <= mb_neg ? -src_b : src_b;
      mneg   <= ma_neg ^ mb_neg;
    end else if ((state == ST_CALC) && !is_div && (cnt != CNT_LAST)) begin
      if (mplier[0]) begin
        acc <= acc + mcand;
      end
      mcand  <= {mcand[2*WIDTH-2:0], 1'b0};
      mplier <= {1'b0, mplier[WIDTH-1:1]};
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= MD_MUL;
      a_q       <= '0;
      b_q       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else if (flush) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_q  <= op;
            a_q   <= src_a;
            b_q   <= src_b;
            cnt   <= '0;
            state <= ST_CALC;
          end
        end
        ST_CALC: begin
          if (is_div) begin
            if ((cnt == '0) && div_zero) begin
              result    <= is_rem ? a_q : '1;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else if ((cnt == '0) && div_ovf) begin
              result    <= is_rem ? '0 : a_q;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else if (cnt == CNT_LAST) begin
              result    <= is_rem ? div_rem : div_quo;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (mul_fin) begin
            result    <= mul_res;
            out_valid <= 1'b1;
            state     <= ST_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
